// File: rtl/alu_result_packer.sv
// alu_result_packer
// Return path of the UART ALU. Captures one ALU result (opcode + 64-bit
// value) and serialises it into a framed byte stream for the UART TX:
//   byte 0 opcode, byte 1 reserved, bytes 2/3 total frame length (LE),
//   then the payload, least significant byte first.
// The payload is WIDE_BYTES long for WIDE_OPCODE and NARROW_BYTES otherwise.
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   opcode_i        opcode of the result, sampled with result_valid_i
//   result_i        64-bit ALU result, sampled with result_valid_i
//   result_valid_i  single-cycle result strobe from the ALU
//   ready_o         packer idle; a result_valid_i this cycle is accepted
//   tx_data_o       byte towards the UART transmitter
//   tx_valid_o      tx_data_o valid
//   tx_ready_i      UART TX takes the byte when tx_valid_o & tx_ready_i
//   overrun_o       sticky flag: a result arrived while busy and was dropped
module alu_result_packer #(
    parameter logic [7:0] WIDE_OPCODE  = 8'hAC,
    parameter int         NARROW_BYTES = 4,
    parameter int         WIDE_BYTES   = 8,
    parameter logic [7:0] RSVD_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  opcode_i,
    input  logic [63:0] result_i,
    input  logic        result_valid_i,
    output logic        ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  nbytes_q, nbytes_d;
    logic        overrun_q, overrun_d;

    logic        accept;
    logic [3:0]  last_idx;
    logic [15:0] frame_len;
    logic [2:0]  pay_sel;

    // One index runs across the whole frame: 0..3 header, 4..3+N payload.
    assign accept    = (state_q != ST_IDLE) && tx_ready_i;
    assign last_idx  = 4'd3 + nbytes_q;
    assign frame_len = 16'd4 + {12'd0, nbytes_q};
    // Payload index 4..11 maps to byte 0..7; modulo-8 subtraction does it.
    assign pay_sel   = idx_q[2:0] - 3'd4;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        nbytes_d  = nbytes_q;
        // A strobe while busy (including the last-byte acceptance cycle) is dropped.
        overrun_d = overrun_q | (result_valid_i && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (result_valid_i) begin
                    opcode_d = opcode_i;
                    result_d = result_i;
                    nbytes_d = (opcode_i == WIDE_OPCODE) ? 4'(WIDE_BYTES)
                                                         : 4'(NARROW_BYTES);
                    idx_d    = 4'd0;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd3) begin
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (accept) begin
                    if (idx_q == last_idx) begin
                        idx_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output byte is a pure function of registered state, so it cannot
    // change while a byte waits for tx_ready_i.
    always_comb begin
        tx_data_o = 8'h00;
        case (state_q)
            ST_HDR: begin
                case (idx_q[1:0])
                    2'd0:    tx_data_o = opcode_q;
                    2'd1:    tx_data_o = RSVD_BYTE;
                    2'd2:    tx_data_o = frame_len[7:0];
                    default: tx_data_o = frame_len[15:8];
                endcase
            end
            ST_PAY:  tx_data_o = result_q[{pay_sel, 3'b000} +: 8];
            default: tx_data_o = 8'h00;
        endcase
    end

    assign tx_valid_o = (state_q != ST_IDLE);
    assign ready_o    = (state_q == ST_IDLE);
    assign overrun_o  = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            opcode_q  <= 8'h00;
            result_q  <= 64'h0;
            nbytes_q  <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
            nbytes_q  <= nbytes_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
